time_cmd_decoder: RTL and testbench

Byte-stream command decoder that drives the stopwatch/clock from a serial link instead of physical buttons. It consumes already-received bytes (rx_data/rx_valid) and produces single-cycle run/clear pulses for the stopwatch. It also produces a validated hour/min/sec load for the clock. It sits between the UART receiver and the button-mode/clock blocks, in parallel with the debounced button path.

---
 rtl/time_cmd_decoder_pkg.sv | 33 +++
 rtl/cmd_timeout_timer.sv | 32 +++
 rtl/time_cmd_decoder.sv | 148 ++++++++++++++
 tb/tb_time_cmd_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_cmd_decoder_pkg.sv
// Shared definitions for the serial time-command decoder: ASCII codes,
// decoder state encoding and time-of-day limits.
package time_cmd_decoder_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_R_UP  = 8'h52;
  localparam logic [7:0] ASCII_R_LO  = 8'h72;
  localparam logic [7:0] ASCII_C_UP  = 8'h43;
  localparam logic [7:0] ASCII_C_LO  = 8'h63;
  localparam logic [7:0] ASCII_S_UP  = 8'h53;
  localparam logic [7:0] ASCII_S_LO  = 8'h73;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam logic [6:0] HOUR_MAX = 7'd23;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] SEC_MAX  = 7'd59;

  localparam int NUM_DIGITS = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIGIT   = 2'd1,
    ST_WAIT_CR = 2'd2
  } state_e;

  // Two decimal digits to a 7-bit value (max 99), wide enough to range-check.
  function automatic logic [6:0] pair_value(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte timeout: counts while enabled, restarts on clear, and pulses
// expire (combinationally) on the cycle the count sits at TIMEOUT_CYC-1.
module cmd_timeout_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q;
  logic         at_last;

  assign at_last = (cnt_q == LAST);
  assign expire  = enable && !clear && at_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear || !enable || at_last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/time_cmd_decoder.sv
// Serial command decoder: turns R/C/S bytes into stopwatch pulses and a
// range-checked hh:mm:ss load for the clock.
module time_cmd_decoder
  import time_cmd_decoder_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TIMEOUT_MS  = 1000,
  parameter int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       o_btn_run,
  output logic       o_btn_clear,
  output logic       o_set_load,
  output logic [4:0] o_set_hour,
  output logic [5:0] o_set_min,
  output logic [5:0] o_set_sec,
  output logic       o_err,
  output logic       o_busy,
  output logic [1:0] dbg_state
);

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure; a byte
  // is consumed on every cycle rx_valid is high, including back-to-back.

  state_e state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [NUM_DIGITS-1:0][3:0] digit_q;
  logic dig_we;
  logic run_d, clr_d, load_d, err_d;
  logic expire;
  logic [6:0] hour_val, min_val, sec_val;
  logic in_range, is_digit;

  assign dbg_state = state_q;

  cmd_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_valid),
    .enable (state_q != ST_IDLE),
    .expire (expire)
  );

  assign is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
  assign hour_val = pair_value(digit_q[0], digit_q[1]);
  assign min_val  = pair_value(digit_q[2], digit_q[3]);
  assign sec_val  = pair_value(digit_q[4], digit_q[5]);
  assign in_range = (hour_val <= HOUR_MAX) && (min_val <= MIN_MAX) && (sec_val <= SEC_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // A received byte always takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dig_we  = 1'b0;
    run_d   = 1'b0;
    clr_d   = 1'b0;
    load_d  = 1'b0;
    err_d   = 1'b0;
    if (rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data == ASCII_R_UP || rx_data == ASCII_R_LO) begin
            run_d = 1'b1;
          end else if (rx_data == ASCII_C_UP || rx_data == ASCII_C_LO) begin
            clr_d = 1'b1;
          end else if (rx_data == ASCII_S_UP || rx_data == ASCII_S_LO) begin
            state_d = ST_DIGIT;
            count_d = '0;
          end else if (rx_data != ASCII_CR && rx_data != ASCII_LF) begin
            err_d = 1'b1;
          end
        end
        ST_DIGIT: begin
          if (is_digit) begin
            dig_we  = 1'b1;
            count_d = count_q + 3'd1;
            if (count_q == 3'(NUM_DIGITS - 1)) begin
              state_d = ST_WAIT_CR;
            end
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_CR: begin
          state_d = ST_IDLE;
          if (rx_data == ASCII_CR && in_range) begin
            load_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (expire) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_q     <= '0;
      o_btn_run   <= 1'b0;
      o_btn_clear <= 1'b0;
      o_set_load  <= 1'b0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
      o_set_hour  <= '0;
      o_set_min   <= '0;
      o_set_sec   <= '0;
    end else begin
      // ASCII '0'..'9' carry their value in the low nibble.
      if (dig_we) begin
        digit_q[count_q] <= rx_data[3:0];
      end
      o_btn_run   <= run_d;
      o_btn_clear <= clr_d;
      o_set_load  <= load_d;
      o_err       <= err_d;
      o_busy      <= (state_d != ST_IDLE);
      if (load_d) begin
        o_set_hour <= hour_val[4:0];
        o_set_min  <= min_val[5:0];
        o_set_sec  <= sec_val[5:0];
      end
    end
  end

endmodule

// File: tb/tb_time_cmd_decoder.sv
// Directed bench for time_cmd_decoder with a short inter-byte timeout.
module tb_time_cmd_decoder;

  localparam int TO_CYC = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       o_btn_run, o_btn_clear, o_set_load, o_err, o_busy;
  logic [4:0] o_set_hour;
  logic [5:0] o_set_min, o_set_sec;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_passed = 0;
  int run_cnt = 0, clr_cnt = 0, load_cnt = 0, err_cnt = 0;
  int excl_bad = 0, load_busy_bad = 0;

  time_cmd_decoder #(
    .CLK_HZ      (1000),
    .TIMEOUT_MS  (16),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .o_btn_run   (o_btn_run),
    .o_btn_clear (o_btn_clear),
    .o_set_load  (o_set_load),
    .o_set_hour  (o_set_hour),
    .o_set_min   (o_set_min),
    .o_set_sec   (o_set_sec),
    .o_err       (o_err),
    .o_busy      (o_busy),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Pulse monitor: every high cycle of a pulse output is counted once.
  always @(posedge clk) begin
    #2;
    if (o_btn_run)   run_cnt++;
    if (o_btn_clear) clr_cnt++;
    if (o_set_load)  load_cnt++;
    if (o_err)       err_cnt++;
    if (int'(o_btn_run) + int'(o_btn_clear) + int'(o_set_load) + int'(o_err) > 1) excl_bad++;
    if (o_set_load && o_busy) load_busy_bad++;
  end

  // Driver tasks: called on a negedge, return on the following negedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_hour"}, 32'(o_set_hour), 32'(h));
    check({tag, "_min"},  32'(o_set_min),  32'(m));
    check({tag, "_sec"},  32'(o_set_sec),  32'(s));
  endtask

  initial begin
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_run",   32'(o_btn_run),   0);
    check("rst_clear", 32'(o_btn_clear), 0);
    check("rst_load",  32'(o_set_load),  0);
    check("rst_err",   32'(o_err),       0);
    check("rst_busy",  32'(o_busy),      0);
    check("rst_state", 32'(dbg_state),   0);
    check_time("rst", 0, 0, 0);
    rst = 1'b1;
    idle(2);
    check("release_err", 32'(err_cnt), 0);

    // Run then clear, back to back
    send_byte("R");
    send_byte("c");
    idle(2);
    check("rc_run",   32'(run_cnt), 1);
    check("rc_clear", 32'(clr_cnt), 1);
    check("rc_err",   32'(err_cnt), 0);
    check("rc_busy",  32'(o_busy),  0);

    // CR / LF ignored in IDLE
    send_byte(8'h0D);
    send_byte(8'h0A);
    idle(2);
    check("crlf_err", 32'(err_cnt), 0);

    // Valid load 12:34:56
    send_str("S123");
    idle(1);
    check("s123_busy",  32'(o_busy),    1);
    check("s123_state", 32'(dbg_state), 1);
    send_str("456");
    idle(1);
    check("wait_cr_state", 32'(dbg_state), 2);
    send_byte(8'h0D);
    idle(2);
    check("load1_cnt",  32'(load_cnt), 1);
    check("load1_busy", 32'(o_busy),   0);
    check("load1_err",  32'(err_cnt),  0);
    check_time("load1", 12, 34, 56);

    // Lowercase s, all zeros, then reload 12:34:56
    send_str("s000000");
    send_byte(8'h0D);
    idle(2);
    check("load0_cnt", 32'(load_cnt), 2);
    check_time("load0", 0, 0, 0);
    send_str("S123456");
    send_byte(8'h0D);
    idle(2);
    check("reload_cnt", 32'(load_cnt), 3);

    // Out-of-range hour and minute
    send_str("S245959");
    send_byte(8'h0D);
    send_str("S236000");
    send_byte(8'h0D);
    idle(2);
    check("range_err",  32'(err_cnt),  2);
    check("range_load", 32'(load_cnt), 3);
    check_time("range_keep", 12, 34, 56);

    // Upper boundary accepted
    send_str("S235959");
    send_byte(8'h0D);
    idle(2);
    check("max_load", 32'(load_cnt), 4);
    check_time("max", 23, 59, 59);

    // Non-digit aborts, byte is consumed; following C is a clear
    send_str("S12a");
    send_byte("C");
    idle(2);
    check("abort_err",   32'(err_cnt), 3);
    check("abort_clear", 32'(clr_cnt), 2);
    check("abort_busy",  32'(o_busy),  0);

    // Seventh digit instead of CR
    send_str("S1234567");
    idle(2);
    check("seventh_err",  32'(err_cnt),  4);
    check("seventh_load", 32'(load_cnt), 4);
    check("seventh_busy", 32'(o_busy),   0);
    check("seventh_run",  32'(run_cnt),  1);

    // Timeout: 16 silent cycles after the last byte
    send_str("S12");
    idle(TO_CYC - 1);
    check("to_pre_err",  32'(err_cnt), 4);
    check("to_pre_busy", 32'(o_busy),  1);
    idle(1);
    check("to_err",   32'(err_cnt), 5);
    check("to_busy",  32'(o_busy),  0);
    idle(TO_CYC + 4);
    check("to_once",  32'(err_cnt), 5);

    // Byte landing on the expiry cycle wins
    send_str("S12");
    idle(TO_CYC - 1);
    send_byte("0");
    idle(2);
    check("race_err",  32'(err_cnt), 5);
    check("race_busy", 32'(o_busy),  1);
    send_str("000");
    send_byte(8'h0D);
    idle(2);
    check("race_load", 32'(load_cnt), 5);
    check_time("race", 12, 0, 0);

    // Reset mid-command
    send_str("S1234");
    rst = 1'b0;
    idle(2);
    check("midrst_busy",  32'(o_busy),    0);
    check("midrst_state", 32'(dbg_state), 0);
    check("midrst_pulse", 32'({o_btn_run, o_btn_clear, o_set_load, o_err}), 0);
    check_time("midrst", 0, 0, 0);
    rst = 1'b1;
    idle(2);
    check("midrst_rel_err", 32'(err_cnt), 5);
    send_str("S010203");
    send_byte(8'h0D);
    idle(2);
    check("post_rst_load", 32'(load_cnt), 6);
    check("post_rst_err",  32'(err_cnt),  5);
    check_time("post_rst", 1, 2, 3);

    // Global pulse properties
    check("exclusive",      32'(excl_bad),      0);
    check("load_busy_low",  32'(load_busy_bad), 0);
    check("final_run",      32'(run_cnt),       1);
    check("final_clear",    32'(clr_cnt),       2);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
